// File: rtl/preamble_insert.sv
// preamble_insert: prepends an 802.11a-style training preamble to each payload frame.
//   Optional macro LONG_PREAMBLE_EN: adds the LONG state and 64-entry long ROM
//   (320-sample preamble). Without it the preamble is the 160-sample short part only.
// Ports:
//   Clk, Rst_n                      clock, async active-low reset
//   DataInEnable/Re/Im/Last         upstream payload samples (valid/ready handshake)
//   DataInReady                     sample accepted when DataInEnable & DataInReady
//   OutputEnable, DataOutRe/Im      registered transmit stream, data zero when idle
//   FrameStart                      pulse on the first preamble sample
module preamble_insert (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       DataInEnable,
    input  logic [7:0] DataInRe,
    input  logic [7:0] DataInIm,
    input  logic       DataInLast,
    output logic       DataInReady,
    output logic       OutputEnable,
    output logic [7:0] DataOutRe,
    output logic [7:0] DataOutIm,
    output logic       FrameStart
);
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] SEQ_LAST = CNT_W'(159);

    // Short training sequence, 16 samples
    localparam logic signed [SAMPLE_W-1:0] SHORT_RE [16] = '{
        8'sd41, -8'sd117, -8'sd12, 8'sd127, 8'sd82, 8'sd127, -8'sd12, -8'sd117,
        8'sd41, 8'sd2, -8'sd70, -8'sd12, 8'sd0, -8'sd12, -8'sd70, 8'sd2};
    localparam logic signed [SAMPLE_W-1:0] SHORT_IM [16] = '{
        8'sd41, 8'sd2, -8'sd70, -8'sd12, 8'sd0, -8'sd12, -8'sd70, 8'sd2,
        8'sd41, -8'sd117, -8'sd12, 8'sd127, 8'sd82, 8'sd127, -8'sd12, -8'sd117};

`ifdef LONG_PREAMBLE_EN
    // Long training sequence, 64 samples
    localparam logic signed [SAMPLE_W-1:0] LONG_RE [64] = '{
        8'sd123, -8'sd4, 8'sd32, 8'sd77, 8'sd17, 8'sd47, -8'sd91, -8'sd30,
        8'sd77, 8'sd42, 8'sd1, -8'sd108, 8'sd19, 8'sd47, -8'sd17, 8'sd94,
        8'sd49, 8'sd29, -8'sd45, -8'sd103, 8'sd65, 8'sd55, -8'sd47, -8'sd44,
        -8'sd28, -8'sd96, -8'sd100, 8'sd59, -8'sd2, -8'sd73, 8'sd73, 8'sd9,
        -8'sd123, 8'sd9, 8'sd73, -8'sd73, -8'sd2, 8'sd59, -8'sd100, -8'sd96,
        -8'sd28, -8'sd44, -8'sd47, 8'sd55, 8'sd65, -8'sd103, -8'sd45, 8'sd29,
        8'sd49, 8'sd94, -8'sd17, 8'sd47, 8'sd19, -8'sd108, 8'sd1, 8'sd42,
        8'sd77, -8'sd30, -8'sd91, 8'sd47, 8'sd17, 8'sd77, 8'sd32, -8'sd4};
    localparam logic signed [SAMPLE_W-1:0] LONG_IM [64] = '{
        8'sd0, -8'sd95, -8'sd88, 8'sd66, 8'sd22, -8'sd70, -8'sd43, -8'sd84,
        -8'sd21, 8'sd3, -8'sd91, -8'sd37, -8'sd47, -8'sd12, 8'sd127, 8'sd3,
        8'sd49, -8'sd77, -8'sd31, -8'sd51, -8'sd73, -8'sd11, -8'sd64, 8'sd17,
        8'sd119, 8'sd13, 8'sd17, 8'sd58, -8'sd43, -8'sd91, -8'sd84, -8'sd77,
        8'sd0, 8'sd77, 8'sd84, 8'sd91, 8'sd43, -8'sd58, -8'sd17, -8'sd13,
        -8'sd119, -8'sd17, 8'sd64, 8'sd11, 8'sd73, 8'sd51, 8'sd31, 8'sd77,
        -8'sd49, -8'sd3, -8'sd127, 8'sd12, 8'sd47, 8'sd37, 8'sd91, -8'sd3,
        8'sd21, 8'sd84, 8'sd43, 8'sd70, -8'sd22, -8'sd66, 8'sd88, 8'sd95};

    typedef enum logic [1:0] {IDLE, SHORT, LONG, DATA} state_e;
`else
    typedef enum logic [1:0] {IDLE, SHORT, DATA} state_e;
`endif

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 ready_q, ready_d;
    logic                 oe_q, oe_d;
    logic                 fs_q, fs_d;
    logic [SAMPLE_W-1:0]  re_q, re_d, im_q, im_d;
    logic                 xfer;
    logic                 to_payload;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign xfer    = DataInEnable & ready_q;

`ifdef LONG_PREAMBLE_EN
    // Long sample n uses ROM entry (n+32) mod 64: 32..63 then 0..63 twice
    logic [5:0] long_idx;
    assign long_idx = cnt_inc[5:0] + 6'd32;
`endif

    // Next state and next registered outputs (outputs describe the cycle after this one)
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = 1'b0;
        oe_d       = 1'b0;
        fs_d       = 1'b0;
        re_d       = '0;
        im_d       = '0;
        to_payload = 1'b0;

        case (state_q)
            IDLE: begin
                if (DataInEnable) begin
                    state_d = SHORT;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    fs_d    = 1'b1;
                    re_d    = SHORT_RE[4'd0];
                    im_d    = SHORT_IM[4'd0];
                end
            end
            SHORT: begin
                if (cnt_q == SEQ_LAST) begin
`ifdef LONG_PREAMBLE_EN
                    state_d = LONG;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    re_d    = LONG_RE[6'd32];
                    im_d    = LONG_IM[6'd32];
`else
                    to_payload = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_inc;
                    oe_d  = 1'b1;
                    re_d  = SHORT_RE[cnt_inc[3:0]];
                    im_d  = SHORT_IM[cnt_inc[3:0]];
`ifndef LONG_PREAMBLE_EN
                    // Ready rises on the final preamble cycle so payload follows with no bubble
                    ready_d = (cnt_inc == SEQ_LAST);
`endif
                end
            end
`ifdef LONG_PREAMBLE_EN
            LONG: begin
                if (cnt_q == SEQ_LAST) begin
                    to_payload = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                    oe_d    = 1'b1;
                    re_d    = LONG_RE[long_idx];
                    im_d    = LONG_IM[long_idx];
                    ready_d = (cnt_inc == SEQ_LAST);
                end
            end
`endif
            DATA:    to_payload = 1'b1;
            default: state_d = IDLE;
        endcase

        // Payload pass-through, also taken on the final preamble cycle
        if (to_payload) begin
            ready_d = 1'b1;
            if (state_q != DATA) begin
                state_d = DATA;
                cnt_d   = '0;
            end
            if (xfer) begin
                oe_d = 1'b1;
                re_d = DataInRe;
                im_d = DataInIm;
                if (state_q == DATA) cnt_d = cnt_inc;
                if (DataInLast) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            oe_q    <= 1'b0;
            fs_q    <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            oe_q    <= oe_d;
            fs_q    <= fs_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign DataInReady  = ready_q;
    assign OutputEnable = oe_q;
    assign FrameStart   = fs_q;
    assign DataOutRe    = re_q;
    assign DataOutIm    = im_q;

endmodule

// File: tb/tb_preamble_insert.sv
// tb_preamble_insert: directed self-checking bench for preamble_insert.
//   Follows LONG_PREAMBLE_EN the same way as the design (320 vs 160 preamble samples).
module tb_preamble_insert;
`ifdef LONG_PREAMBLE_EN
    localparam int PRE = 320;
`else
    localparam int PRE = 160;
`endif

    logic       Clk;
    logic       Rst_n;
    logic       DataInEnable;
    logic [7:0] DataInRe;
    logic [7:0] DataInIm;
    logic       DataInLast;
    logic       DataInReady;
    logic       OutputEnable;
    logic [7:0] DataOutRe;
    logic [7:0] DataOutIm;
    logic       FrameStart;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scaled training tables, hand-derived from the 802.11a time-domain sequences
    int S_RE[16] = '{41, -117, -12, 127, 82, 127, -12, -117, 41, 2, -70, -12, 0, -12, -70, 2};
    int S_IM[16] = '{41, 2, -70, -12, 0, -12, -70, 2, 41, -117, -12, 127, 82, 127, -12, -117};
    int L_RE[64] = '{123, -4, 32, 77, 17, 47, -91, -30, 77, 42, 1, -108, 19, 47, -17, 94,
                     49, 29, -45, -103, 65, 55, -47, -44, -28, -96, -100, 59, -2, -73, 73, 9,
                     -123, 9, 73, -73, -2, 59, -100, -96, -28, -44, -47, 55, 65, -103, -45, 29,
                     49, 94, -17, 47, 19, -108, 1, 42, 77, -30, -91, 47, 17, 77, 32, -4};
    int L_IM[64] = '{0, -95, -88, 66, 22, -70, -43, -84, -21, 3, -91, -37, -47, -12, 127, 3,
                     49, -77, -31, -51, -73, -11, -64, 17, 119, 13, 17, 58, -43, -91, -84, -77,
                     0, 77, 84, 91, 43, -58, -17, -13, -119, -17, 64, 11, 73, 51, 31, 77,
                     -49, -3, -127, 12, 47, 37, 91, -3, 21, 84, 43, 70, -22, -66, 88, 95};

    preamble_insert dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .DataInEnable (DataInEnable),
        .DataInRe     (DataInRe),
        .DataInIm     (DataInIm),
        .DataInLast   (DataInLast),
        .DataInReady  (DataInReady),
        .OutputEnable (OutputEnable),
        .DataOutRe    (DataOutRe),
        .DataOutIm    (DataOutIm),
        .FrameStart   (FrameStart)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Preamble sample k: short entries k mod 16, then long entries 32..63, 0..63, 0..63
    function automatic void pre_exp(input int k, output int re, output int im);
        int j;
        if (k < 160) begin
            re = S_RE[k % 16];
            im = S_IM[k % 16];
        end else begin
            j = k - 160;
            if (j < 32)      j = j + 32;
            else if (j < 96) j = j - 32;
            else             j = j - 96;
            re = L_RE[j];
            im = L_IM[j];
        end
    endfunction

    task automatic check_out(input string tag, input int fs, input int oe, input int re, input int im);
        check_eq({tag, "_fs"}, int'(FrameStart), fs);
        check_eq({tag, "_oe"}, int'(OutputEnable), oe);
        check_eq({tag, "_re"}, int'($signed(DataOutRe)), re);
        check_eq({tag, "_im"}, int'($signed(DataOutIm)), im);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_out("idle", 0, 0, 0, 0);
            check_eq("idle_ready", int'(DataInReady), 0);
        end
    endtask

    // Drives one frame starting in IDLE at a negedge and checks every output cycle.
    // gap_at: DATA-phase cycle offset (from the final preamble cycle) with DataInEnable low.
    task automatic run_frame(input int n_pay, input int base, input int gap_at, input bit last_pre,
                             output int fs_cyc, output int last_cyc);
        int  sent, c, er, ei, pr, pi;
        bit  acc, acc_prev, exp_ready, done;
        sent = 0; acc_prev = 1'b0; done = 1'b0; pr = 0; pi = 0; c = 0;
        fs_cyc = -1; last_cyc = -1;
        while (!done && c < PRE + n_pay + 16) begin
            if (c >= 1 && c <= PRE) begin
                pre_exp(c - 1, er, ei);
                check_out("pre", (c == 1) ? 1 : 0, 1, er, ei);
                if (c == 1) fs_cyc = cyc;
            end else if (c > PRE) begin
                check_out("pay", 0, int'(acc_prev), acc_prev ? pr : 0, acc_prev ? pi : 0);
            end
            exp_ready = (c >= PRE) && (sent < n_pay);
            check_eq("ready", int'(DataInReady), int'(exp_ready));
            if (sent == n_pay && acc_prev) begin
                done     = 1'b1;
                last_cyc = cyc;
            end else begin
                DataInEnable = (sent < n_pay) && (c - PRE != gap_at);
                DataInRe     = 8'(base + 9 * sent);
                DataInIm     = 8'(-base - 5 * sent);
                DataInLast   = exp_ready ? (sent == n_pay - 1) : last_pre;
                acc = DataInEnable && exp_ready;
                step();
                if (acc) begin
                    pr = base + 9 * sent;
                    pi = -base - 5 * sent;
                    sent++;
                end
                acc_prev = acc;
                c++;
            end
        end
        check_eq("frame_done", int'(done), 1);
        check_eq("payload_count", sent, n_pay);
    endtask

    initial begin
        int fs_a, last_a, fs_b, last_b;
        Rst_n = 1'b0; DataInEnable = 1'b0; DataInRe = '0; DataInIm = '0; DataInLast = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check_out("reset", 0, 0, 0, 0);
        check_eq("reset_ready", int'(DataInReady), 0);
        Rst_n = 1'b1;
        idle_cycles(3);

        // Four-sample frame, enable held high
        run_frame(4, 10, -1000, 1'b0, fs_a, last_a);
        DataInEnable = 1'b0; DataInLast = 1'b0;
        check_eq("frame1_len", last_a - fs_a, PRE + 3);
        idle_cycles(3);

        // Single-sample frame
        run_frame(1, 40, -1000, 1'b0, fs_a, last_a);
        DataInEnable = 1'b0; DataInLast = 1'b0;
        check_eq("single_len", last_a - fs_a, PRE);
        idle_cycles(2);

        // Upstream gap during DATA
        run_frame(5, 20, 1, 1'b0, fs_a, last_a);
        DataInEnable = 1'b0; DataInLast = 1'b0;
        check_eq("gap_len", last_a - fs_a, PRE + 5);
        idle_cycles(2);

        // DataInLast high throughout the preamble must not end the frame
        run_frame(3, 30, -1000, 1'b1, fs_a, last_a);
        DataInEnable = 1'b0; DataInLast = 1'b0;
        check_eq("last_pre_len", last_a - fs_a, PRE + 2);
        idle_cycles(2);

        // Back-to-back frames
        run_frame(2, 50, -1000, 1'b0, fs_a, last_a);
        run_frame(2, 60, -1000, 1'b0, fs_b, last_b);
        DataInEnable = 1'b0; DataInLast = 1'b0;
        check_eq("b2b_gap_ok", int'(fs_b - last_a >= 1), 1);
        idle_cycles(2);

        // Reset at short sample 50
        DataInEnable = 1'b1;
        for (int i = 0; i < 51; i++) step();
        check_out("abort_pre", 0, 1, S_RE[2], S_IM[2]);
        DataInEnable = 1'b0;
        Rst_n = 1'b0;
        #1;
        check_out("abort_rst", 0, 0, 0, 0);
        check_eq("abort_ready", int'(DataInReady), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        idle_cycles(5);
        run_frame(2, 70, -1000, 1'b0, fs_a, last_a);
        DataInEnable = 1'b0; DataInLast = 1'b0;
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
